// File: rtl/rvc_compressor_if.sv
// rvc_compressor_if
//   Handshake bundle for rvc_compressor. Signal names keep their
//   design-side direction suffixes so that existing connection lists
//   still read naturally.
//   Input channel : in_valid_i, in_ready_o, in_instr_i[31:0]
//   Flush control : flush_i, flush_done_o
//   Output channel: out_valid_o, out_ready_i, out_word_o[31:0]
//   Statistics    : cmp_cnt_o[CNT_W-1:0]
//   Modports: slave (the compressor), master (the producer/consumer side).
interface rvc_compressor_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      in_instr_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      out_word_o;
  logic             flush_done_o;
  logic [CNT_W-1:0] cmp_cnt_o;

  modport slave (
    input  in_valid_i, in_instr_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_word_o, flush_done_o, cmp_cnt_o
  );

  modport master (
    output in_valid_i, in_instr_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_word_o, flush_done_o, cmp_cnt_o
  );
endinterface

// File: rtl/rvc_compressor.sv
// rvc_compressor
//   Streaming RV32 -> RVC compressor and halfword packer. A fixed subset of
//   RV32I (c.li, c.addi, c.mv, c.add, c.lw, c.sw, c.jr forms) is re-encoded
//   to 16 bits; everything else passes through as a 32-bit parcel. Parcels
//   are packed into little-endian 32-bit words (bits [15:0] = lower address).
//   A flush emits any pending half padded with c.nop (16'h0001).
//
//   Compile-time option: RVC_COMPRESS_EN. When undefined every instruction
//   is a 32-bit parcel, the packer never holds a half and the counter stays 0.
//
//   Ports:
//     clk_i   - clock, rising edge
//     rst_ni  - synchronous active-low reset
//     bus     - rvc_compressor_if.slave: input handshake + instruction,
//               flush request/done pulse, output handshake + word,
//               compressed-instruction counter
module rvc_compressor #(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  rvc_compressor_if.slave    bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_pend, w_pend_nxt;
  logic             r_out_valid;
  logic [31:0]      r_out_word;
  logic             r_flush_done;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_flush_go;
  logic             w_load;
  logic [31:0]      w_load_word;
  logic             w_flush_pulse;
  logic             w_cnt_inc;
  logic             w_is_c;
  logic [15:0]      w_cparcel;

  // Single-entry output register: free when empty or being drained.
  assign bus.in_ready_o   = !r_out_valid || bus.out_ready_i;
  assign w_accept         = bus.in_valid_i && bus.in_ready_o;
  // A flush loses to a simultaneous valid input; the requester keeps it up.
  assign w_flush_go       = bus.flush_i && !bus.in_valid_i && bus.in_ready_o;

  assign bus.out_valid_o  = r_out_valid;
  assign bus.out_word_o   = r_out_word;
  assign bus.flush_done_o = r_flush_done;
  assign bus.cmp_cnt_o    = r_cnt;

`ifdef RVC_COMPRESS_EN
  logic [31:0] w_ins;
  logic [6:0]  w_opc;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [11:0] w_iimm, w_simm;
  logic        w_imm6;

  assign w_ins  = bus.in_instr_i;
  assign w_opc  = w_ins[6:0];
  assign w_rd   = w_ins[11:7];
  assign w_f3   = w_ins[14:12];
  assign w_rs1  = w_ins[19:15];
  assign w_rs2  = w_ins[24:20];
  assign w_f7   = w_ins[31:25];
  assign w_iimm = w_ins[31:20];
  assign w_simm = {w_ins[31:25], w_ins[11:7]};
  // Immediate fits the 6-bit signed CI field when bits [11:5] are a pure
  // sign extension of bit 5.
  assign w_imm6 = (w_iimm[11:5] == {7{w_iimm[5]}});

  always_comb begin
    w_is_c    = 1'b0;
    w_cparcel = '0;
    if (w_opc == 7'b0010011 && w_f3 == 3'b000 && w_rd != 5'd0 &&
        w_rs1 == 5'd0 && w_imm6) begin
      w_is_c    = 1'b1;   // c.li
      w_cparcel = {3'b010, w_iimm[5], w_rd, w_iimm[4:0], 2'b01};
    end else if (w_opc == 7'b0010011 && w_f3 == 3'b000 && w_rd != 5'd0 &&
                 w_rs1 == w_rd && w_iimm != 12'd0 && w_imm6) begin
      w_is_c    = 1'b1;   // c.addi
      w_cparcel = {3'b000, w_iimm[5], w_rd, w_iimm[4:0], 2'b01};
    end else if (w_opc == 7'b0110011 && w_f3 == 3'b000 && w_f7 == 7'd0 &&
                 w_rd != 5'd0 && w_rs1 == 5'd0 && w_rs2 != 5'd0) begin
      w_is_c    = 1'b1;   // c.mv
      w_cparcel = {4'b1000, w_rd, w_rs2, 2'b10};
    end else if (w_opc == 7'b0110011 && w_f3 == 3'b000 && w_f7 == 7'd0 &&
                 w_rd != 5'd0 && w_rs1 == w_rd && w_rs2 != 5'd0) begin
      w_is_c    = 1'b1;   // c.add
      w_cparcel = {4'b1001, w_rd, w_rs2, 2'b10};
    end else if (w_opc == 7'b0000011 && w_f3 == 3'b010 &&
                 w_rd[4:3] == 2'b01 && w_rs1[4:3] == 2'b01 &&
                 w_iimm[11:7] == 5'd0 && w_iimm[1:0] == 2'b00) begin
      w_is_c    = 1'b1;   // c.lw
      w_cparcel = {3'b010, w_iimm[5:3], w_rs1[2:0], w_iimm[2], w_iimm[6],
                   w_rd[2:0], 2'b00};
    end else if (w_opc == 7'b0100011 && w_f3 == 3'b010 &&
                 w_rs2[4:3] == 2'b01 && w_rs1[4:3] == 2'b01 &&
                 w_simm[11:7] == 5'd0 && w_simm[1:0] == 2'b00) begin
      w_is_c    = 1'b1;   // c.sw
      w_cparcel = {3'b110, w_simm[5:3], w_rs1[2:0], w_simm[2], w_simm[6],
                   w_rs2[2:0], 2'b00};
    end else if (w_opc == 7'b1100111 && w_f3 == 3'b000 && w_rd == 5'd0 &&
                 w_iimm == 12'd0 && w_rs1 != 5'd0) begin
      w_is_c    = 1'b1;   // c.jr
      w_cparcel = {4'b1000, w_rs1, 5'd0, 2'b10};
    end
  end
`else
  assign w_is_c    = 1'b0;
  assign w_cparcel = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_EMPTY;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pend_nxt    = r_pend;
    w_load        = 1'b0;
    w_load_word   = r_out_word;
    w_flush_pulse = 1'b0;
    w_cnt_inc     = 1'b0;
    if (w_accept) begin
      w_cnt_inc = w_is_c;
      unique case (r_state)
        ST_EMPTY: begin
          if (w_is_c) begin
            w_pend_nxt  = w_cparcel;
            w_state_nxt = ST_HALF;
          end else begin
            w_load      = 1'b1;
            w_load_word = bus.in_instr_i;
          end
        end
        ST_HALF: begin
          w_load = 1'b1;
          if (w_is_c) begin
            w_load_word = {w_cparcel, r_pend};
            w_state_nxt = ST_EMPTY;
          end else begin
            // 32-bit parcel straddles: low half completes this word,
            // high half becomes the new pending half.
            w_load_word = {bus.in_instr_i[15:0], r_pend};
            w_pend_nxt  = bus.in_instr_i[31:16];
          end
        end
      endcase
    end else if (w_flush_go) begin
      w_flush_pulse = 1'b1;
      if (r_state == ST_HALF) begin
        w_load      = 1'b1;
        w_load_word = {16'h0001, r_pend};
        w_state_nxt = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pend       <= '0;
      r_out_valid  <= 1'b0;
      r_out_word   <= '0;
      r_flush_done <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_pend       <= w_pend_nxt;
      r_flush_done <= w_flush_pulse;
      if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_word  <= w_load_word;
      end else if (bus.out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rvc_compressor.sv
module tb_rvc_compressor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef RVC_COMPRESS_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  rvc_compressor_if #(.CNT_W(16)) bus ();

  rvc_compressor #(.CNT_W(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid_i  = 1'b0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.in_instr_i  = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Present one instruction until it is accepted (bounded).
  task automatic send(input logic [31:0] instr);
    int unsigned n = 0;
    bit ok = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_instr_i = instr;
    while (!ok && n < 50) begin
      ok = bus.in_ready_o;
      tick();
      n++;
    end
    bus.in_valid_i = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept instr=%08h got not-accepted want accepted", instr);
    end
  endtask

  task automatic do_flush();
    int unsigned n = 0;
    bit ok = 1'b0;
    bus.flush_i = 1'b1;
    while (!ok && n < 50) begin
      ok = bus.in_ready_o && !bus.in_valid_i;
      tick();
      n++;
    end
    bus.flush_i = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL flush_accept got not-accepted want accepted");
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid_o); end
    checks++; if (bus.out_word_o !== 32'h0) begin errors++; $display("FAIL reset_out_word got %08h want 00000000", bus.out_word_o); end
    checks++; if (bus.flush_done_o !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %0b want 0", bus.flush_done_o); end
    checks++; if (bus.cmp_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cmp_cnt got %0d want 0", bus.cmp_cnt_o); end
    checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready_o); end
  endtask

  task automatic test_pair();
    logic [31:0] w;
    do_reset();
    send(32'h00140413);
    checks++; if (bus.out_valid_o !== !EN) begin errors++; $display("FAIL pair_first_valid got %0b want %0b", bus.out_valid_o, !EN); end
    send(32'h00500493);
    w = EN ? 32'h44950405 : 32'h00500493;
    checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL pair_valid got %0b want 1", bus.out_valid_o); end
    checks++; if (bus.out_word_o !== w) begin errors++; $display("FAIL pair_word got %08h want %08h", bus.out_word_o, w); end
    checks++; if (bus.cmp_cnt_o !== (EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL pair_cnt got %0d want %0d", bus.cmp_cnt_o, EN ? 2 : 0); end
    tick();
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL pair_drain got %0b want 0", bus.out_valid_o); end
  endtask

  task automatic test_clw();
    do_reset();
    send(32'h0085A503);
    do_flush();
    checks++; if (bus.flush_done_o !== 1'b1) begin errors++; $display("FAIL clw_flush_done got %0b want 1", bus.flush_done_o); end
    checks++; if (bus.out_valid_o !== EN) begin errors++; $display("FAIL clw_valid got %0b want %0b", bus.out_valid_o, EN); end
    if (EN) begin
      checks++; if (bus.out_word_o !== 32'h00014588) begin errors++; $display("FAIL clw_word got %08h want 00014588", bus.out_word_o); end
    end
    tick();
    checks++; if (bus.flush_done_o !== 1'b0) begin errors++; $display("FAIL clw_done_pulse got %0b want 0", bus.flush_done_o); end
  endtask

  task automatic test_straddle();
    logic [31:0] w;
    do_reset();
    send(32'h00140413);
    send(32'h123452B7);
    w = EN ? 32'h52B70405 : 32'h123452B7;
    checks++; if (bus.out_word_o !== w || bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL straddle_word1 got %08h/%0b want %08h/1", bus.out_word_o, bus.out_valid_o, w); end
    do_flush();
    checks++; if (bus.out_valid_o !== EN) begin errors++; $display("FAIL straddle_flush_valid got %0b want %0b", bus.out_valid_o, EN); end
    if (EN) begin
      checks++; if (bus.out_word_o !== 32'h00011234) begin errors++; $display("FAIL straddle_word2 got %08h want 00011234", bus.out_word_o); end
    end
    checks++; if (bus.flush_done_o !== 1'b1) begin errors++; $display("FAIL straddle_done got %0b want 1", bus.flush_done_o); end
    checks++; if (bus.cmp_cnt_o !== (EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL straddle_cnt got %0d want %0d", bus.cmp_cnt_o, EN ? 1 : 0); end
  endtask

  task automatic test_passthrough();
    do_reset();
    send(32'h123452B7);
    checks++; if (bus.out_valid_o !== 1'b1 || bus.out_word_o !== 32'h123452B7) begin errors++; $display("FAIL passthrough got %08h/%0b want 123452b7/1", bus.out_word_o, bus.out_valid_o); end
  endtask

  task automatic test_rules();
    logic [31:0] v_in   [9] = '{32'h006002B3, 32'h006282B3, 32'h06942E23, 32'h00008067,
                                32'hFE000413, 32'hFFF40413, 32'h02040413, 32'h00040413, 32'h0083A503};
    logic        en_val [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] en_word[9] = '{32'h0, 32'h929A829A, 32'h0, 32'h8082DC64,
                                32'h0, 32'h147D5401, 32'h02040413, 32'h00040413, 32'h0083A503};
    logic        ev;
    logic [31:0] ew;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(v_in[i]);
      ev = EN ? en_val[i] : 1'b1;
      ew = EN ? en_word[i] : v_in[i];
      checks++; if (bus.out_valid_o !== ev) begin errors++; $display("FAIL rules_valid[%0d] got %0b want %0b", i, bus.out_valid_o, ev); end
      if (ev) begin
        checks++; if (bus.out_word_o !== ew) begin errors++; $display("FAIL rules_word[%0d] got %08h want %08h", i, bus.out_word_o, ew); end
      end
    end
    checks++; if (bus.cmp_cnt_o !== (EN ? 16'd6 : 16'd0)) begin errors++; $display("FAIL rules_cnt got %0d want %0d", bus.cmp_cnt_o, EN ? 6 : 0); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w1, w2;
    do_reset();
    bus.out_ready_i = 1'b0;
    if (EN) send(32'h00140413);
    send(32'h123452B7);
    w1 = EN ? 32'h52B70405 : 32'h123452B7;
    w2 = EN ? 32'h44951234 : 32'h00500493;
    bus.in_valid_i = 1'b1;
    bus.in_instr_i = 32'h00500493;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b want 0", c, bus.in_ready_o); end
      checks++; if (bus.out_valid_o !== 1'b1 || bus.out_word_o !== w1) begin errors++; $display("FAIL bp_hold[%0d] got %08h/%0b want %08h/1", c, bus.out_word_o, bus.out_valid_o, w1); end
      tick();
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    checks++; if (bus.out_valid_o !== 1'b1 || bus.out_word_o !== w2) begin errors++; $display("FAIL bp_second got %08h/%0b want %08h/1", bus.out_word_o, bus.out_valid_o, w2); end
    tick();
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %0b want 0", bus.out_valid_o); end
    checks++; if (bus.cmp_cnt_o !== (EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL bp_cnt got %0d want %0d", bus.cmp_cnt_o, EN ? 2 : 0); end
  endtask

  task automatic test_flush_empty();
    do_reset();
    do_flush();
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty_valid got %0b want 0", bus.out_valid_o); end
    checks++; if (bus.flush_done_o !== 1'b1) begin errors++; $display("FAIL flush_empty_done got %0b want 1", bus.flush_done_o); end
    tick();
    checks++; if (bus.flush_done_o !== 1'b0) begin errors++; $display("FAIL flush_empty_pulse got %0b want 0", bus.flush_done_o); end
  endtask

  task automatic test_flush_ignored();
    logic [31:0] w;
    do_reset();
    if (EN) send(32'h00140413);
    bus.in_valid_i = 1'b1;
    bus.in_instr_i = 32'h123452B7;
    bus.flush_i    = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    w = EN ? 32'h52B70405 : 32'h123452B7;
    checks++; if (bus.flush_done_o !== 1'b0) begin errors++; $display("FAIL flush_ign_done got %0b want 0", bus.flush_done_o); end
    checks++; if (bus.out_word_o !== w) begin errors++; $display("FAIL flush_ign_word got %08h want %08h", bus.out_word_o, w); end
    tick();
    bus.flush_i = 1'b0;
    checks++; if (bus.flush_done_o !== 1'b1) begin errors++; $display("FAIL flush_held_done got %0b want 1", bus.flush_done_o); end
    checks++; if (bus.out_valid_o !== EN) begin errors++; $display("FAIL flush_held_valid got %0b want %0b", bus.out_valid_o, EN); end
    if (EN) begin
      checks++; if (bus.out_word_o !== 32'h00011234) begin errors++; $display("FAIL flush_held_word got %08h want 00011234", bus.out_word_o); end
    end
  endtask

  task automatic test_reset_mid_half();
    do_reset();
    send(32'h00140413);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (bus.out_valid_o !== 1'b0 || bus.out_word_o !== 32'h0 || bus.flush_done_o !== 1'b0 || bus.cmp_cnt_o !== 16'd0) begin
      errors++; $display("FAIL midreset_outputs got v=%0b w=%08h d=%0b c=%0d want all 0", bus.out_valid_o, bus.out_word_o, bus.flush_done_o, bus.cmp_cnt_o);
    end
    do_flush();
    checks++; if (bus.out_valid_o !== 1'b0 || bus.out_word_o !== 32'h0) begin errors++; $display("FAIL midreset_flush_word got %08h/%0b want 00000000/0", bus.out_word_o, bus.out_valid_o); end
    checks++; if (bus.flush_done_o !== 1'b1) begin errors++; $display("FAIL midreset_flush_done got %0b want 1", bus.flush_done_o); end
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_instr_i  = '0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    test_reset();
    test_pair();
    test_clw();
    test_straddle();
    test_passthrough();
    test_rules();
    test_backpressure();
    test_flush_empty();
    test_flush_ignored();
    test_reset_mid_half();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
